// File: rtl/enemy_anim_src.sv
// Animated, mirrorable enemy sprite pixel source with a tear-free origin.
// Ports: clk, reset_n | x, y scan position | frame_start pulse |
//   x0, y0, mirror, anim_en, period shadow controls | we, addr_w, pixel_in
//   sprite RAM write | enemy_rgb, hit (2-cycle latency), cur_frame.
module enemy_anim_src #(
    parameter int CD = 12,
    parameter int H_SIZE = 64,
    parameter int V_SIZE = 64,
    parameter int FRAMES = 4,
    parameter logic [CD-1:0] KEY_COLOR = '0,
    parameter int PER_W = 8,
    localparam int HW = $clog2(H_SIZE),
    localparam int VW = $clog2(V_SIZE),
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int ADDR = FW + VW + HW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      x,
    input  logic [10:0]      y,
    input  logic             frame_start,
    input  logic [10:0]      x0,
    input  logic [10:0]      y0,
    input  logic             mirror,
    input  logic             anim_en,
    input  logic [PER_W-1:0] period,
    input  logic             we,
    input  logic [ADDR-1:0]  addr_w,
    input  logic [CD-1:0]    pixel_in,
    output logic [CD-1:0]    enemy_rgb,
    output logic             hit,
    output logic [FW-1:0]    cur_frame
);

    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
    localparam logic [FW:0]   FRAME_LIM  = (FW + 1)'(FRAMES);

    logic [10:0]      act_x0;
    logic [10:0]      act_y0;
    logic             act_mirror;
    logic             act_anim;
    logic [PER_W-1:0] act_period;
    logic [PER_W-1:0] tick_cnt;
    logic [FW-1:0]    frame_q;

    logic [11:0]      xr;
    logic [11:0]      yr;
    logic             in_region;
    logic             in_region_d;
    logic [HW-1:0]    col;
    logic [ADDR-1:0]  addr_r;
    logic [FW:0]      wr_frame;
    logic             wr_ok;
    logic [CD-1:0]    dout;

    logic [CD-1:0]    mem [2**ADDR];

    assign cur_frame = frame_q;

    // Animation step uses the active values from before this frame's load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_x0     <= '0;
            act_y0     <= '0;
            act_mirror <= 1'b0;
            act_anim   <= 1'b0;
            act_period <= '0;
            tick_cnt   <= '0;
            frame_q    <= '0;
        end else if (frame_start) begin
            act_x0     <= x0;
            act_y0     <= y0;
            act_mirror <= mirror;
            act_anim   <= anim_en;
            act_period <= period;
            if (act_anim) begin
                if (tick_cnt < act_period) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    tick_cnt <= '0;
                    frame_q  <= (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
                end
            end
        end
    end

    // 12-bit signed offsets: an origin near 2047 yields a negative
    // offset instead of wrapping into view.
    assign xr = {1'b0, x} - {1'b0, act_x0};
    assign yr = {1'b0, y} - {1'b0, act_y0};

    assign in_region = (xr[11:HW] == '0) && (yr[11:VW] == '0);

    assign col = act_mirror ? (HW'(H_SIZE - 1) - xr[HW-1:0]) : xr[HW-1:0];

    assign addr_r = {frame_q, yr[VW-1:0], col};

    // Writes aimed at a frame slot beyond FRAMES-1 are discarded.
    assign wr_frame = {1'b0, addr_w[ADDR-1 -: FW]};
    assign wr_ok    = wr_frame < FRAME_LIM;

    // Read-before-write: a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[addr_w] <= pixel_in;
        end
        dout <= mem[addr_r];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_region_d <= 1'b0;
            enemy_rgb   <= KEY_COLOR;
            hit         <= 1'b0;
        end else begin
            in_region_d <= in_region;
            enemy_rgb   <= in_region_d ? dout : KEY_COLOR;
            hit         <= in_region_d;
        end
    end

endmodule

// File: tb/tb_enemy_anim_src.sv
// Directed bench for enemy_anim_src: reset, latency, mirror, animation,
// tear-free origin, RAM collision and out-of-range frame writes.
module tb_enemy_anim_src;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] x, y, x0, y0;
    logic        frame_start, mirror, anim_en, we;
    logic [7:0]  period;
    logic [13:0] addr_w;
    logic [11:0] pixel_in;

    logic [11:0] rgb, rgb3;
    logic        hit, hit3;
    logic [1:0]  cur_frame, cur_frame3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    enemy_anim_src #(.FRAMES(4)) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y),
        .frame_start(frame_start), .x0(x0), .y0(y0),
        .mirror(mirror), .anim_en(anim_en), .period(period),
        .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
        .enemy_rgb(rgb), .hit(hit), .cur_frame(cur_frame)
    );

    enemy_anim_src #(.FRAMES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y),
        .frame_start(frame_start), .x0(x0), .y0(y0),
        .mirror(mirror), .anim_en(anim_en), .period(period),
        .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
        .enemy_rgb(rgb3), .hit(hit3), .cur_frame(cur_frame3)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wr(input logic [1:0] f, input logic [5:0] r,
                      input logic [5:0] c, input logic [11:0] d);
        we = 1'b1;
        addr_w = {f, r, c};
        pixel_in = d;
        step(1);
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        x = 0; y = 0; x0 = 0; y0 = 0;
        frame_start = 0; mirror = 0; anim_en = 0; period = 0;
        we = 0; addr_w = 0; pixel_in = 0;
        step(3);
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_out rgb=%h hit=%b exp 000/0", rgb, hit);
        end
        checks++;
        if (cur_frame !== 2'd0) begin
            errors++;
            $display("FAIL reset_frame got=%0d exp=0", cur_frame);
        end
        reset_n = 1'b1;
        wr(2'd0, 6'd0, 6'd0, 12'h5A5);
        step(3);
        checks++;
        if (rgb !== 12'h5A5 || hit !== 1'b1) begin
            errors++;
            $display("FAIL origin_pix rgb=%h hit=%b exp 5a5/1", rgb, hit);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
            errors++;
            $display("FAIL async_reset rgb=%h hit=%b exp 000/0", rgb, hit);
        end
        step(1);
        reset_n = 1'b1;
        step(1);
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL release_lat1 hit=%b exp 0", hit);
        end
        step(1);
        checks++;
        if (rgb !== 12'h5A5 || hit !== 1'b1) begin
            errors++;
            $display("FAIL release_lat2 rgb=%h hit=%b exp 5a5/1", rgb, hit);
        end
    endtask

    task automatic test_region();
        x0 = 100; y0 = 50;
        pulse();
        wr(2'd0, 6'd3, 6'd5, 12'hABC);
        step(3);
        x = 105; y = 53;
        step(1);
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL region_lat1 hit=%b exp 0", hit);
        end
        step(1);
        checks++;
        if (rgb !== 12'hABC || hit !== 1'b1) begin
            errors++;
            $display("FAIL region_lat2 rgb=%h hit=%b exp abc/1", rgb, hit);
        end
        x = 99;
        step(2);
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
            errors++;
            $display("FAIL region_left rgb=%h hit=%b exp 000/0", rgb, hit);
        end
        x = 164;
        step(2);
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
            errors++;
            $display("FAIL region_right rgb=%h hit=%b exp 000/0", rgb, hit);
        end
        x = 105; y = 49;
        step(2);
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
            errors++;
            $display("FAIL region_top rgb=%h hit=%b exp 000/0", rgb, hit);
        end
        x0 = 2040;
        pulse();
        x = 5; y = 53;
        step(3);
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
            errors++;
            $display("FAIL origin_wrap rgb=%h hit=%b exp 000/0", rgb, hit);
        end
        x0 = 100;
        pulse();
    endtask

    task automatic test_mirror();
        mirror = 1'b1;
        pulse();
        x = 158; y = 53;
        step(3);
        checks++;
        if (rgb !== 12'hABC || hit !== 1'b1) begin
            errors++;
            $display("FAIL mirror_pix rgb=%h hit=%b exp abc/1", rgb, hit);
        end
        mirror = 1'b0;
        step(3);
        checks++;
        if (rgb !== 12'hABC || hit !== 1'b1) begin
            errors++;
            $display("FAIL mirror_shadow rgb=%h hit=%b exp abc/1", rgb, hit);
        end
        pulse();
    endtask

    task automatic test_tear();
        x0 = 300;
        x = 105; y = 53;
        step(3);
        checks++;
        if (rgb !== 12'hABC || hit !== 1'b1) begin
            errors++;
            $display("FAIL tear_old rgb=%h hit=%b exp abc/1", rgb, hit);
        end
        x = 305;
        step(3);
        checks++;
        if (rgb !== 12'h000 || hit !== 1'b0) begin
            errors++;
            $display("FAIL tear_new_early rgb=%h hit=%b exp 000/0", rgb, hit);
        end
        pulse();
        step(2);
        checks++;
        if (rgb !== 12'hABC || hit !== 1'b1) begin
            errors++;
            $display("FAIL tear_new rgb=%h hit=%b exp abc/1", rgb, hit);
        end
        x0 = 100;
        pulse();
        x = 105;
        step(3);
    endtask

    task automatic test_collision();
        wr(2'd0, 6'd3, 6'd5, 12'hDEF);
        step(1);
        checks++;
        if (rgb !== 12'hABC) begin
            errors++;
            $display("FAIL collide_old rgb=%h exp abc", rgb);
        end
        step(1);
        checks++;
        if (rgb !== 12'hDEF) begin
            errors++;
            $display("FAIL collide_new rgb=%h exp def", rgb);
        end
    endtask

    task automatic test_drop();
        wr(2'd3, 6'd3, 6'd5, 12'h777);
        step(3);
        checks++;
        if (rgb3 !== 12'hDEF || hit3 !== 1'b1) begin
            errors++;
            $display("FAIL drop_f3 rgb=%h hit=%b exp def/1", rgb3, hit3);
        end
        checks++;
        if (rgb !== 12'hDEF) begin
            errors++;
            $display("FAIL drop_f0 rgb=%h exp def", rgb);
        end
    endtask

    task automatic test_anim();
        int e4, e3;
        anim_en = 1'b1;
        period = 8'd2;
        for (int p = 1; p <= 13; p++) begin
            pulse();
            e4 = ((p - 1) / 3) % 4;
            e3 = ((p - 1) / 3) % 3;
            checks++;
            if (cur_frame !== 2'(e4)) begin
                errors++;
                $display("FAIL anim4_p%0d got=%0d exp=%0d", p, cur_frame, e4);
            end
            checks++;
            if (cur_frame3 !== 2'(e3)) begin
                errors++;
                $display("FAIL anim3_p%0d got=%0d exp=%0d", p, cur_frame3, e3);
            end
            if (e4 == 3) begin
                step(2);
                checks++;
                if (rgb !== 12'h777) begin
                    errors++;
                    $display("FAIL anim_f3_pix p%0d rgb=%h exp 777", p, rgb);
                end
            end
            if (e3 == 0) begin
                step(2);
                checks++;
                if (rgb3 !== 12'hDEF) begin
                    errors++;
                    $display("FAIL anim3_f0_pix p%0d rgb=%h exp def", p, rgb3);
                end
            end
        end
        anim_en = 1'b0;
        for (int i = 0; i < 5; i++) pulse();
        checks++;
        if (cur_frame !== 2'd0 || cur_frame3 !== 2'd1) begin
            errors++;
            $display("FAIL freeze got=%0d/%0d exp 0/1", cur_frame, cur_frame3);
        end
        anim_en = 1'b1;
        pulse();
        pulse();
        checks++;
        if (cur_frame !== 2'd0 || cur_frame3 !== 2'd1) begin
            errors++;
            $display("FAIL resume_a got=%0d/%0d exp 0/1", cur_frame, cur_frame3);
        end
        pulse();
        checks++;
        if (cur_frame !== 2'd1 || cur_frame3 !== 2'd2) begin
            errors++;
            $display("FAIL resume_b got=%0d/%0d exp 1/2", cur_frame, cur_frame3);
        end
    endtask

    initial begin
        test_reset();
        test_region();
        test_mirror();
        test_tear();
        test_collision();
        test_drop();
        test_anim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
